ysyx_22040895_ifu: RTL and testbench
====================================

// Module: ysyx_22040895_ifu
// PURPOSE
//  Instruction fetch unit; directly downstream of the PC register. Accepts the fetch PC and chip
//  enable, issues a read on a valid/ready memory port, selects the 32-bit word, holds it for decode.
//  Drives if_ready_o back so the PC stage advances only when a PC is accepted; supports branch flush.
// PARAMETERS
//  ADDR_W    64            fetch address width
//  DATA_W    64            memory read data width (two instructions per beat)
//  NOP_INST  32'h00000013  value driven on inst_o when no valid instruction (addi x0,x0,0)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, synchronous, active-high
//  pc_i           in   ADDR_W  fetch PC from PC register
//  ce_i           in   1       PC valid (PC register chip enable)
//  if_ready_o     out  1       IFU accepts pc_i this cycle; PC stage must hold when low
//  flush_i        in   1       branch redirect: discard in-flight/held fetch
//  mem_arvalid_o  out  1       read request valid
//  mem_arready_i  in   1       read request accepted
//  mem_araddr_o   out  ADDR_W  read address, 8-byte aligned
//  mem_rvalid_i   in   1       read data valid
//  mem_rready_o   out  1       IFU accepts read data
//  mem_rdata_i    in   DATA_W  read data
//  mem_rerr_i     in   1       read error, qualified by mem_rvalid_i
//  inst_valid_o   out  1       inst_o/inst_pc_o valid to decode
//  idu_ready_i    in   1       decode accepts instruction
//  inst_o         out  32      fetched instruction
//  inst_pc_o      out  ADDR_W  PC of inst_o
//  exc_o          out  2       0 none, 1 misaligned PC, 2 access fault; qualified by inst_valid_o
//  fetch_cnt_o    out  64      count of instructions handed to decode
// BEHAVIOUR
//  Reset: state IDLE, drop_q=0; arvalid/rready/inst_valid=0, araddr=0, inst_o=NOP_INST,
//   inst_pc_o=0, exc_o=0, fetch_cnt_o=0; if_ready_o=0 while rst. Reset mid-op aborts all; any
//   late rvalid is ignored in IDLE.
//  if_ready_o (comb) = !rst & !flush_i & (IDLE | (HOLD & idu_ready_i)). Accept = if_ready_o & ce_i.
//  States IDLE, REQ, WAIT, HOLD:
//   IDLE: on accept, latch pc_q=pc_i. pc_i[1:0]!=0 -> HOLD, exc=1, inst=NOP, no mem access.
//    Else araddr={pc_i[ADDR_W-1:3],3'b0}, arvalid=1 -> REQ.
//   REQ: arvalid/araddr stable until mem_arready_i; then arvalid=0 -> WAIT. Never withdrawn.
//   WAIT: rready=1. On rvalid: inst=pc_q[2]?rdata[63:32]:rdata[31:0], exc=rerr?2:0;
//    if drop_q: discard, drop_q=0 -> IDLE; else inst_valid=1 -> HOLD.
//   HOLD: outputs stable while idu_ready_i=0. On idu_ready_i: fetch_cnt+=1 (wraps at 2^64);
//    if ce_i same cycle, back-to-back accept (IDLE rules) -> REQ/HOLD; else inst_valid=0 -> IDLE.
//  Latency: accept at cycle N, arready N+1, rvalid N+2 -> inst_valid_o at N+3; 1 beat per
//   3 cycles min. Memory stalls add cycles one-for-one.
//  flush_i priority over every event, same cycle:
//   IDLE/HOLD: inst_valid=0, inst=NOP -> IDLE; held inst not counted even if idu_ready_i=1.
//   REQ: request still completes; set drop_q -> WAIT. WAIT: set drop_q (or drop rvalid now).
//   pc_i never accepted while flush_i=1; redirected PC accepted next cycle in IDLE.
//  Only one outstanding request; rvalid outside WAIT ignored.
// TESTING
//  pc=0x80000000, arready/rvalid immediate, rdata=0x00100093_00000513 -> inst=0x00000513,
//   pc_o=0x80000000, valid at cycle 3, araddr=0x80000000.
//  pc=0x80000004, same rdata -> inst=0x00100093; idu_ready_i low 4 cycles -> outputs hold,
//   fetch_cnt unchanged until handshake, then 1.
//  arready delayed 3 cycles -> arvalid/araddr stable; inst_valid after 6 cycles; if_ready_o=0.
//  flush in WAIT, rvalid next cycle -> data dropped, inst_valid stays 0, IDLE, new pc accepted.
//  pc=0x80000002 -> no arvalid, inst_valid next cycle with exc=1, inst=NOP; rerr=1 -> exc=2.
//  rst asserted in REQ -> all outputs at reset values next cycle; stray rvalid ignored.

Source files
------------

// File: rtl/ysyx_22040895_ifu.sv
// ysyx_22040895_ifu -- instruction fetch unit
//
// Sits directly after the PC register. It accepts a fetch PC and issues one
// 64-bit read on a valid/ready memory port. It then selects the 32-bit
// instruction from the returned beat and holds that instruction for decode
// until decode takes it. At most one read is in flight at any time.
//
// Handshake rule used on every channel: a transfer happens on a rising clock
// edge where valid and ready are both high. Once a source raises valid, it
// keeps valid and its payload stable until that transfer happens. A sink may
// drive ready from its own state. The IFU is the source on the read-request
// channel (mem_arvalid_o/mem_araddr_o) and on the decode channel
// (inst_valid_o/inst_o/inst_pc_o/exc_o). It is the sink on the read-data
// channel (mem_rready_o) and on the PC channel (if_ready_o, with ce_i as
// valid).
//
// Ports
//   clk, rst                 clock (rising edge); synchronous active-high reset
//   pc_i, ce_i, if_ready_o   fetch PC in; PC valid; PC accepted this cycle
//   flush_i                  branch redirect, discards in-flight/held fetch
//   mem_ar*                  read request: valid, ready, 8-byte aligned addr
//   mem_r*                   read data: valid, ready, data, error
//   inst_valid_o, idu_ready_i, inst_o, inst_pc_o, exc_o   decode channel
//                            (exc: 0 none, 1 misaligned PC, 2 access fault)
//   fetch_cnt_o              instructions handed to decode (wraps)
//   state_o                  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 HOLD)
module ysyx_22040895_ifu #(
    parameter int          ADDR_W   = 64,
    parameter int          DATA_W   = 64,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic              if_ready_o,
    input  logic              flush_i,
    output logic              mem_arvalid_o,
    input  logic              mem_arready_i,
    output logic [ADDR_W-1:0] mem_araddr_o,
    input  logic              mem_rvalid_i,
    output logic              mem_rready_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rerr_i,
    output logic              inst_valid_o,
    input  logic              idu_ready_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [1:0]        exc_o,
    output logic [63:0]       fetch_cnt_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [31:0]       inst_q, inst_d;
    logic [1:0]        exc_q, exc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [63:0]       cnt_q, cnt_d;
    logic              accept;

    // A PC is taken only from IDLE, or from HOLD in the same cycle that
    // decode takes the held instruction. This lets fetches run back to back.
    always_comb begin
        if_ready_o = !rst && !flush_i &&
                     ((state_q == S_IDLE) || ((state_q == S_HOLD) && idu_ready_i));
        accept     = if_ready_o && ce_i;
    end

    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        pc_d      = pc_q;
        araddr_d  = araddr_q;
        inst_d    = inst_q;
        exc_d     = exc_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                // Nothing here; a new PC is taken by the accept block below.
            end
            S_REQ: begin
                // A request that has been issued is never withdrawn. A flush
                // only marks the returning beat to be thrown away.
                if (flush_i) drop_d = 1'b1;
                if (mem_arready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    inst_d = pc_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
                    exc_d  = mem_rerr_i ? 2'd2 : 2'd0;
                    if (drop_q || flush_i) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (idu_ready_i) begin
                    cnt_d   = cnt_q + 64'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept overrides the HOLD->IDLE exit above when it happens back to back.
        if (accept) begin
            pc_d = pc_i;
            if (pc_i[1:0] != 2'b00) begin
                // A misaligned PC never reaches memory. It is reported as an exception.
                inst_d    = NOP_INST;
                exc_d     = 2'd1;
                inst_pc_d = pc_i;
                state_d   = S_HOLD;
            end else begin
                araddr_d = {pc_i[ADDR_W-1:3], 3'b000};
                state_d  = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            drop_q    <= 1'b0;
            pc_q      <= '0;
            araddr_q  <= '0;
            inst_q    <= NOP_INST;
            exc_q     <= 2'd0;
            inst_pc_q <= '0;
            cnt_q     <= 64'd0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            pc_q      <= pc_d;
            araddr_q  <= araddr_d;
            inst_q    <= inst_d;
            exc_q     <= exc_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Channel valids/readies come straight from the state. Outside HOLD the
    // decode payload is forced to NOP with no exception.
    always_comb begin
        mem_arvalid_o = (state_q == S_REQ);
        mem_araddr_o  = araddr_q;
        mem_rready_o  = (state_q == S_WAIT);
        inst_valid_o  = (state_q == S_HOLD);
        inst_o        = (state_q == S_HOLD) ? inst_q : NOP_INST;
        exc_o         = (state_q == S_HOLD) ? exc_q : 2'd0;
        inst_pc_o     = inst_pc_q;
        fetch_cnt_o   = cnt_q;
        state_o       = state_q;
    end

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
module tb_ysyx_22040895_ifu;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [63:0] pc_i;
  logic        ce_i;
  logic        if_ready_o;
  logic        flush_i;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [63:0] mem_araddr_o;
  logic        mem_rvalid_i;
  logic        mem_rready_o;
  logic [63:0] mem_rdata_i;
  logic        mem_rerr_i;
  logic        inst_valid_o;
  logic        idu_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic [1:0]  exc_o;
  logic [63:0] fetch_cnt_o;
  logic [1:0]  state_o;

  int total;
  int passed;
  int fails;

  ysyx_22040895_ifu dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .if_ready_o(if_ready_o),
    .flush_i(flush_i), .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
    .mem_araddr_o(mem_araddr_o), .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
    .mem_rdata_i(mem_rdata_i), .mem_rerr_i(mem_rerr_i), .inst_valid_o(inst_valid_o),
    .idu_ready_i(idu_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o), .exc_o(exc_o),
    .fetch_cnt_o(fetch_cnt_o), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [63:0] cnt);
    chk({tag, "_state"}, state_o, 2'd0);
    chk({tag, "_arvalid"}, mem_arvalid_o, 1'b0);
    chk({tag, "_rready"}, mem_rready_o, 1'b0);
    chk({tag, "_ivalid"}, inst_valid_o, 1'b0);
    chk({tag, "_inst"}, inst_o, NOP);
    chk({tag, "_exc"}, exc_o, 2'd0);
    chk({tag, "_cnt"}, fetch_cnt_o, cnt);
  endtask

  initial begin
    total = 0; passed = 0; fails = 0;
    rst = 1'b1; pc_i = '0; ce_i = 1'b1; flush_i = 1'b0;
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_rerr_i = 1'b0;
    idu_ready_i = 1'b0;

    // reset state
    cyc(); cyc();
    chk_idle_outputs("rst", 64'd0);
    chk("rst_araddr", mem_araddr_o, 64'd0);
    chk("rst_inst_pc", inst_pc_o, 64'd0);
    chk("rst_if_ready", if_ready_o, 1'b0);
    ce_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_if_ready", if_ready_o, 1'b1);

    // fetch 0x80000000, immediate memory; early rvalid must be ignored
    cyc();
    pc_i = 64'h8000_0000; ce_i = 1'b1;
    mem_arready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h00100093_00000513;
    cyc();
    ce_i = 1'b0;
    #1;
    chk("f1_state_req", state_o, 2'd1);
    chk("f1_arvalid", mem_arvalid_o, 1'b1);
    chk("f1_araddr", mem_araddr_o, 64'h8000_0000);
    chk("f1_if_ready", if_ready_o, 1'b0);
    cyc();
    chk("f1_rready", mem_rready_o, 1'b1);
    chk("f1_ivalid_early", inst_valid_o, 1'b0);
    cyc();
    chk("f1_ivalid", inst_valid_o, 1'b1);
    chk("f1_inst", inst_o, 32'h00000513);
    chk("f1_inst_pc", inst_pc_o, 64'h8000_0000);
    chk("f1_exc", exc_o, 2'd0);

    // back-to-back handshake + accept of 0x80000004
    idu_ready_i = 1'b1; ce_i = 1'b1; pc_i = 64'h8000_0004;
    #1;
    chk("b2b_if_ready", if_ready_o, 1'b1);
    cyc();
    idu_ready_i = 1'b0; ce_i = 1'b0;
    chk("b2b_cnt", fetch_cnt_o, 64'd1);
    chk("b2b_state_req", state_o, 2'd1);
    chk("b2b_ivalid", inst_valid_o, 1'b0);
    chk("b2b_araddr", mem_araddr_o, 64'h8000_0000);
    cyc(); cyc();
    // decode stalls 4 cycles: everything holds
    for (int i = 0; i < 4; i++) begin
      chk("f2_hold_ivalid", inst_valid_o, 1'b1);
      chk("f2_hold_inst", inst_o, 32'h00100093);
      chk("f2_hold_pc", inst_pc_o, 64'h8000_0004);
      chk("f2_hold_cnt", fetch_cnt_o, 64'd1);
      cyc();
    end
    idu_ready_i = 1'b1;
    cyc();
    idu_ready_i = 1'b0;
    chk_idle_outputs("f2_done", 64'd2);

    // read request accepted only after 3 stalled cycles
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0;
    pc_i = 64'h8000_1008; ce_i = 1'b1;
    cyc();
    ce_i = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ar_stall_arvalid", mem_arvalid_o, 1'b1);
      chk("ar_stall_araddr", mem_araddr_o, 64'h8000_1008);
      chk("ar_stall_if_ready", if_ready_o, 1'b0);
      cyc();
    end
    mem_arready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEADBEEF_12345678;
    chk("ar_last_arvalid", mem_arvalid_o, 1'b1);
    cyc();
    chk("ar_wait_rready", mem_rready_o, 1'b1);
    chk("ar_wait_ivalid", inst_valid_o, 1'b0);
    cyc();
    chk("ar_ivalid", inst_valid_o, 1'b1);
    chk("ar_inst", inst_o, 32'h12345678);
    chk("ar_inst_pc", inst_pc_o, 64'h8000_1008);
    idu_ready_i = 1'b1;
    cyc();
    idu_ready_i = 1'b0;
    chk_idle_outputs("ar_done", 64'd3);

    // flush in WAIT, data arrives next cycle and is dropped
    mem_rvalid_i = 1'b0;
    pc_i = 64'h8000_2000; ce_i = 1'b1;
    cyc();
    ce_i = 1'b0;
    cyc();
    chk("fw_state_wait", state_o, 2'd2);
    flush_i = 1'b1;
    #1;
    chk("fw_if_ready", if_ready_o, 1'b0);
    cyc();
    flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h55555555_66666666;
    chk("fw_still_wait", state_o, 2'd2);
    cyc();
    mem_rvalid_i = 1'b0;
    chk_idle_outputs("fw_dropped", 64'd3);
    pc_i = 64'h8000_3004; ce_i = 1'b1;
    #1;
    chk("fw_new_if_ready", if_ready_o, 1'b1);
    cyc();
    ce_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAAAAAA_BBBBBBBB;
    chk("fw_new_araddr", mem_araddr_o, 64'h8000_3000);
    cyc(); cyc();
    chk("fw_new_inst", inst_o, 32'hAAAAAAAA);
    chk("fw_new_pc", inst_pc_o, 64'h8000_3004);

    // flush in HOLD wins over decode handshake: not counted
    flush_i = 1'b1; idu_ready_i = 1'b1; ce_i = 1'b1;
    #1;
    chk("fh_if_ready", if_ready_o, 1'b0);
    cyc();
    flush_i = 1'b0; idu_ready_i = 1'b0; ce_i = 1'b0;
    chk_idle_outputs("fh", 64'd3);

    // flush in REQ with stalled arready: request stays up, beat dropped
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b1;
    pc_i = 64'h8000_4000; ce_i = 1'b1;
    cyc();
    ce_i = 1'b0; flush_i = 1'b1;
    cyc();
    flush_i = 1'b0; mem_arready_i = 1'b1;
    chk("fr_arvalid_kept", mem_arvalid_o, 1'b1);
    cyc();
    chk("fr_state_wait", state_o, 2'd2);
    cyc();
    mem_rvalid_i = 1'b0;
    chk_idle_outputs("fr_dropped", 64'd3);

    // misaligned PC: no memory access, exception 1
    pc_i = 64'h8000_0002; ce_i = 1'b1;
    cyc();
    ce_i = 1'b0;
    chk("mis_arvalid", mem_arvalid_o, 1'b0);
    chk("mis_ivalid", inst_valid_o, 1'b1);
    chk("mis_exc", exc_o, 2'd1);
    chk("mis_inst", inst_o, NOP);
    chk("mis_pc", inst_pc_o, 64'h8000_0002);
    idu_ready_i = 1'b1;
    cyc();
    idu_ready_i = 1'b0;
    chk_idle_outputs("mis_done", 64'd4);

    // read error: exception 2
    mem_arready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rerr_i = 1'b1;
    mem_rdata_i = 64'h11111111_22222222;
    pc_i = 64'h8000_0010; ce_i = 1'b1;
    cyc();
    ce_i = 1'b0;
    cyc(); cyc();
    chk("err_ivalid", inst_valid_o, 1'b1);
    chk("err_exc", exc_o, 2'd2);
    chk("err_inst", inst_o, 32'h22222222);
    idu_ready_i = 1'b1;
    cyc();
    idu_ready_i = 1'b0; mem_rerr_i = 1'b0;
    chk_idle_outputs("err_done", 64'd5);

    // reset while in REQ, then stray rvalid
    mem_arready_i = 1'b0; mem_rvalid_i = 1'b0;
    pc_i = 64'h8000_5000; ce_i = 1'b1;
    cyc();
    ce_i = 1'b0;
    chk("rr_state_req", state_o, 2'd1);
    rst = 1'b1;
    #1;
    chk("rr_if_ready", if_ready_o, 1'b0);
    cyc();
    rst = 1'b0; mem_rvalid_i = 1'b1;
    chk_idle_outputs("rr", 64'd0);
    chk("rr_araddr", mem_araddr_o, 64'd0);
    chk("rr_inst_pc", inst_pc_o, 64'd0);
    cyc();
    mem_rvalid_i = 1'b0;
    chk_idle_outputs("rr_stray", 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
